m_stop_watch_lap: RTL and testbench

- Next-generation stopwatch: single system clock with an internal 1/100 s tick prescaler, so no derived clocks.
- Synchronised start/stop, lap and clear controls; BCD time mm:ss.cc with lap-capture registers.
- Overflow behaviour is selectable: wrap or saturate.
- Sits between the board switch inputs and the 7-segment/LED display driver.

---
 rtl/m_stop_watch_lap_if.sv | 33 +++
 rtl/m_stop_watch_lap.sv | 164 ++++++++++++++++
 tb/tb_m_stop_watch_lap.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/m_stop_watch_lap_if.sv
// ============================================================================
// Module   : m_stop_watch_lap_if
// Brief    : Switch inputs and BCD display outputs of the lap stopwatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface m_stop_watch_lap_if;
    logic       start_sw;
    logic       lap_sw;
    logic       clr_sw;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] csec;
    logic [7:0] lap_min;
    logic [7:0] lap_sec;
    logic [7:0] lap_csec;
    logic       lap_valid;
    logic       run_led;
    logic       ovf;

    modport master (
        output start_sw, lap_sw, clr_sw,
        input  min, sec, csec, lap_min, lap_sec, lap_csec, lap_valid, run_led, ovf
    );

    modport slave (
        input  start_sw, lap_sw, clr_sw,
        output min, sec, csec, lap_min, lap_sec, lap_csec, lap_valid, run_led, ovf
    );
endinterface

`default_nettype wire

// File: rtl/m_stop_watch_lap.sv
// ============================================================================
// Module   : m_stop_watch_lap
// Brief    : BCD mm:ss.cc stopwatch with lap capture, 1/100 s prescaler and
//            selectable wrap/saturate overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_stop_watch_lap #(
    parameter int CLK_DIV = 500000,
    parameter int MAX_MIN = 59,
    parameter int WRAP    = 1
) (
    input wire logic          clk,
    input wire logic          rst,
    m_stop_watch_lap_if.slave sw_if
);
    localparam int               c_PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PW-1:0]  c_PRE_MAX  = c_PW'(CLK_DIV - 1);
    localparam logic [3:0]       c_MAX_MT   = 4'(MAX_MIN / 10);
    localparam logic [3:0]       c_MAX_MU   = 4'(MAX_MIN % 10);
    localparam bit               c_SAT      = (WRAP == 0);
    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_RUN      = 2'd1;
    localparam logic [1:0]       c_PAUSE    = 2'd2;

    // Bit order in the synchroniser vectors: {clr, lap, start}
    logic [2:0]      r_sync1, r_sync2, r_sync_d;
    logic [2:0]      w_pulse;
    logic            w_start_p, w_lap_p, w_clr_p;

    logic [1:0]      r_state;
    logic            r_run_led, r_ovf;
    logic [c_PW-1:0] r_pres;
    logic [3:0]      r_cu, r_ct, r_su, r_st, r_mu, r_mt;
    logic [3:0]      w_cu_n, w_ct_n, w_su_n, w_st_n, w_mu_n, w_mt_n;
    logic            w_tick, w_c0, w_c1, w_c2, w_c3, w_term;
    logic [7:0]      r_lap_min, r_lap_sec, r_lap_csec;
    logic            r_lap_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_sync_d <= 3'b000;
        end else begin
            r_sync1  <= {sw_if.clr_sw, sw_if.lap_sw, sw_if.start_sw};
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_pulse   = r_sync2 & ~r_sync_d;
    assign w_start_p = w_pulse[0];
    assign w_lap_p   = w_pulse[1];
    assign w_clr_p   = w_pulse[2];

    // All carries are decoded from current digits so the cascade settles in one clock
    assign w_tick = (r_state == c_RUN) && (r_pres == c_PRE_MAX);
    assign w_c0   = w_tick && (r_cu == 4'd9);
    assign w_c1   = w_c0 && (r_ct == 4'd9);
    assign w_c2   = w_c1 && (r_su == 4'd9);
    assign w_c3   = w_c2 && (r_st == 4'd5);
    assign w_term = w_c3 && (r_mt == c_MAX_MT) && (r_mu == c_MAX_MU);

    always_comb begin
        w_cu_n = r_cu;
        w_ct_n = r_ct;
        w_su_n = r_su;
        w_st_n = r_st;
        w_mu_n = r_mu;
        w_mt_n = r_mt;
        if (w_tick && !(w_term && c_SAT)) begin
            w_cu_n = w_c0 ? 4'd0 : r_cu + 4'd1;
            if (w_c0) w_ct_n = w_c1 ? 4'd0 : r_ct + 4'd1;
            if (w_c1) w_su_n = w_c2 ? 4'd0 : r_su + 4'd1;
            if (w_c2) w_st_n = w_c3 ? 4'd0 : r_st + 4'd1;
            if (w_c3) begin
                w_mu_n = (w_term || (r_mu == 4'd9)) ? 4'd0 : r_mu + 4'd1;
                w_mt_n = w_term ? 4'd0 : ((r_mu == 4'd9) ? r_mt + 4'd1 : r_mt);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_run_led <= 1'b0;
            r_ovf     <= 1'b0;
            r_pres    <= '0;
            {r_mt, r_mu, r_st, r_su, r_ct, r_cu} <= 24'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_pres <= '0;
                    r_ovf  <= 1'b0;
                    {r_mt, r_mu, r_st, r_su, r_ct, r_cu} <= 24'h0;
                    if (w_start_p && !w_clr_p) begin
                        r_state   <= c_RUN;
                        r_run_led <= 1'b1;
                    end
                end
                c_RUN: begin
                    {r_mt, r_mu, r_st, r_su, r_ct, r_cu} <=
                        {w_mt_n, w_mu_n, w_st_n, w_su_n, w_ct_n, w_cu_n};
                    r_pres <= w_tick ? '0 : r_pres + c_PW'(1);
                    if (w_term && c_SAT) r_ovf <= 1'b1;
                    if (w_start_p || (w_term && c_SAT)) begin
                        r_state   <= c_PAUSE;
                        r_run_led <= 1'b0;
                    end
                end
                c_PAUSE: begin
                    if (w_clr_p) begin
                        r_state <= c_IDLE;
                        r_pres  <= '0;
                        r_ovf   <= 1'b0;
                        {r_mt, r_mu, r_st, r_su, r_ct, r_cu} <= 24'h0;
                    end else if (w_start_p && !r_ovf) begin
                        r_state   <= c_RUN;
                        r_run_led <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_run_led <= 1'b0;
                end
            endcase
        end
    end

    // Capture uses the pre-tick digits; cleared together with the time on clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_min   <= 8'h00;
            r_lap_sec   <= 8'h00;
            r_lap_csec  <= 8'h00;
            r_lap_valid <= 1'b0;
        end else if ((r_state == c_PAUSE) && w_clr_p) begin
            r_lap_min   <= 8'h00;
            r_lap_sec   <= 8'h00;
            r_lap_csec  <= 8'h00;
            r_lap_valid <= 1'b0;
        end else if ((r_state == c_RUN) && w_lap_p) begin
            r_lap_min   <= {r_mt, r_mu};
            r_lap_sec   <= {r_st, r_su};
            r_lap_csec  <= {r_ct, r_cu};
            r_lap_valid <= 1'b1;
        end
    end

    assign sw_if.min       = {r_mt, r_mu};
    assign sw_if.sec       = {r_st, r_su};
    assign sw_if.csec      = {r_ct, r_cu};
    assign sw_if.lap_min   = r_lap_min;
    assign sw_if.lap_sec   = r_lap_sec;
    assign sw_if.lap_csec  = r_lap_csec;
    assign sw_if.lap_valid = r_lap_valid;
    assign sw_if.run_led   = r_run_led;
    assign sw_if.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_m_stop_watch_lap.sv
// ============================================================================
// Module   : tb_m_stop_watch_lap
// Brief    : Self-checking bench for m_stop_watch_lap (wrap and saturate builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_stop_watch_lap;
    localparam int c_DIV  = 4;
    localparam int c_MAXM = 1;
    localparam int c_TMAX = c_MAXM * 6000 + 5999;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m_stop_watch_lap_if u_if_w ();
    m_stop_watch_lap_if u_if_s ();

    m_stop_watch_lap #(.CLK_DIV(c_DIV), .MAX_MIN(c_MAXM), .WRAP(1)) u_dut_w (
        .clk(clk), .rst(rst), .sw_if(u_if_w.slave));
    m_stop_watch_lap #(.CLK_DIV(c_DIV), .MAX_MIN(c_MAXM), .WRAP(0)) u_dut_s (
        .clk(clk), .rst(rst), .sw_if(u_if_s.slave));

    logic [50:0] obs_w, obs_s;
    assign obs_w = {u_if_w.min, u_if_w.sec, u_if_w.csec, u_if_w.lap_min, u_if_w.lap_sec,
                    u_if_w.lap_csec, u_if_w.lap_valid, u_if_w.run_led, u_if_w.ovf};
    assign obs_s = {u_if_s.min, u_if_s.sec, u_if_s.csec, u_if_s.lap_min, u_if_s.lap_sec,
                    u_if_s.lap_csec, u_if_s.lap_valid, u_if_s.run_led, u_if_s.ovf};

    int nvec = 0;
    int nerr = 0;

    // Times are given in hundredths of a second and converted to the display format
    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [50:0] pack(input int t, input int lt, input bit lv,
                                         input bit rl, input bit ov);
        return {bcd(t / 6000), bcd((t / 100) % 60), bcd(t % 100),
                bcd(lt / 6000), bcd((lt / 100) % 60), bcd(lt % 100), lv, rl, ov};
    endfunction

    task automatic check(input string nm, input logic [50:0] act, input logic [50:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (min,sec,csec,lmin,lsec,lcsec,lv,run,ovf)",
                     nm, act, exp);
        end
    endtask

    // Switch bits {start, lap, clr}; high for one sampling edge, total cyc edges
    task automatic drive(input bit [2:0] w, input bit [2:0] s, input int cyc);
        {u_if_w.start_sw, u_if_w.lap_sw, u_if_w.clr_sw} = w;
        {u_if_s.start_sw, u_if_s.lap_sw, u_if_s.clr_sw} = s;
        @(negedge clk);
        {u_if_w.start_sw, u_if_w.lap_sw, u_if_w.clr_sw} = 3'b000;
        {u_if_s.start_sw, u_if_s.lap_sw, u_if_s.clr_sw} = 3'b000;
        repeat (cyc - 1) @(negedge clk);
    endtask

    // Reference model: time as a plain count of hundredths
    bit       m_wrap[2];
    int       m_t[2], m_lap[2], m_pres[2], m_st[2];   // m_st: 0 idle, 1 run, 2 pause
    bit       m_lv[2], m_ovf[2];
    bit [2:0] hs[2], hl[2], hc[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_lap[i] = 0; m_pres[i] = 0; m_st[i] = 0;
            m_lv[i] = 0; m_ovf[i] = 0; hs[i] = 0; hl[i] = 0; hc[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit s, input bit l, input bit c);
        bit sp, lp, cp, tick;
        sp = hs[i][1] & ~hs[i][2];
        lp = hl[i][1] & ~hl[i][2];
        cp = hc[i][1] & ~hc[i][2];
        hs[i] = {hs[i][1:0], s};
        hl[i] = {hl[i][1:0], l};
        hc[i] = {hc[i][1:0], c};
        case (m_st[i])
            0: begin
                m_t[i] = 0; m_pres[i] = 0;
                if (sp && !cp) m_st[i] = 1;
            end
            1: begin
                tick = (m_pres[i] == c_DIV - 1);
                if (lp) begin m_lap[i] = m_t[i]; m_lv[i] = 1; end
                m_pres[i] = tick ? 0 : m_pres[i] + 1;
                if (tick) begin
                    if (m_t[i] < c_TMAX) m_t[i]++;
                    else if (m_wrap[i]) m_t[i] = 0;
                    else begin m_ovf[i] = 1; m_st[i] = 2; end
                end
                if (sp) m_st[i] = 2;
            end
            default: begin
                if (cp) begin
                    m_t[i] = 0; m_pres[i] = 0; m_lap[i] = 0;
                    m_lv[i] = 0; m_ovf[i] = 0; m_st[i] = 0;
                end else if (sp && !m_ovf[i]) m_st[i] = 1;
            end
        endcase
    endtask

    typedef struct {
        bit st, lp, cl;
        int cyc;
        int t, lapt;
        bit lv, rl, ov;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit sw[2][3];
        tbl = '{
            '{1,0,0,   3,   0,  0, 0, 1, 0},   // start from idle
            '{0,0,0,   4,   1,  0, 0, 1, 0},   // first tick after 4 clocks
            '{0,0,0, 144,  37,  0, 0, 1, 0},
            '{0,1,0,   3,  37, 37, 1, 1, 0},   // lap at 00:00.37
            '{0,0,0,   1,  38, 37, 1, 1, 0},
            '{0,0,0, 248, 100, 37, 1, 1, 0},   // 01.00 s
            '{1,0,0,   3, 100, 37, 1, 0, 0},   // pause
            '{0,0,0,  20, 100, 37, 1, 0, 0},   // frozen
            '{1,0,1,   3,   0,  0, 0, 0, 0},   // clr beats start in pause
            '{1,0,0,   3,   0,  0, 0, 1, 0},
            '{0,0,1,   8,   2,  0, 0, 1, 0},   // clr ignored in run
            '{1,1,0,   3,   2,  2, 1, 0, 0},   // start+lap together
            '{1,0,0,   3,   2,  2, 1, 1, 0},   // resume, fraction kept
            '{0,0,0,   1,   3,  2, 1, 1, 0}
        };

        rst = 1'b1;
        {u_if_w.start_sw, u_if_w.lap_sw, u_if_w.clr_sw} = 3'b000;
        {u_if_s.start_sw, u_if_s.lap_sw, u_if_s.clr_sw} = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_w", obs_w, '0);
        check("reset_s", obs_s, '0);
        rst = 1'b0;

        for (int k = 0; k < 14; k++) begin
            drive({tbl[k].st, tbl[k].lp, tbl[k].cl}, 3'b000, tbl[k].cyc);
            check($sformatf("table[%0d]", k), obs_w,
                  pack(tbl[k].t, tbl[k].lapt, tbl[k].lv, tbl[k].rl, tbl[k].ov));
        end

        // Asynchronous reset while running at 00:03.27
        drive(3'b000, 3'b000, 324 * c_DIV);
        check("run_0327", obs_w, pack(327, 2, 1, 1, 0));
        #2 rst = 1'b1;
        #1 check("async_rst", obs_w, '0);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 3'b000, 10);
        check("after_rst_w", obs_w, '0);
        check("after_rst_s", obs_s, '0);

        // Run both builds to the terminal time
        drive(3'b100, 3'b100, 3);
        drive(3'b000, 3'b000, 100 * c_DIV);
        drive(3'b000, 3'b010, 3);
        drive(3'b000, 3'b000, c_TMAX * c_DIV - 100 * c_DIV - 3);
        check("max_w", obs_w, pack(c_TMAX, 0, 0, 1, 0));
        check("max_s", obs_s, pack(c_TMAX, 100, 1, 1, 0));
        drive(3'b000, 3'b000, c_DIV);
        check("wrap_w", obs_w, pack(0, 0, 0, 1, 0));
        check("sat_s", obs_s, pack(c_TMAX, 100, 1, 0, 1));
        drive(3'b000, 3'b100, 3 + c_DIV);
        check("sat_start_ignored", obs_s, pack(c_TMAX, 100, 1, 0, 1));
        drive(3'b000, 3'b001, 3);
        check("sat_clr", obs_s, '0);

        // Randomised phase against the reference model
        m_wrap[0] = 1'b1;
        m_wrap[1] = 1'b0;
        rst = 1'b1;
        {u_if_w.start_sw, u_if_w.lap_sw, u_if_w.clr_sw} = 3'b000;
        {u_if_s.start_sw, u_if_s.lap_sw, u_if_s.clr_sw} = 3'b000;
        for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) sw[i][j] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            check($sformatf("rand_w[%0d]", n), obs_w,
                  pack(m_t[0], m_lap[0], m_lv[0], m_st[0] == 1, m_ovf[0]));
            check($sformatf("rand_s[%0d]", n), obs_s,
                  pack(m_t[1], m_lap[1], m_lv[1], m_st[1] == 1, m_ovf[1]));
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 3; j++)
                    if ($urandom_range(0, 9) == 0) sw[i][j] = ~sw[i][j];
                model_step(i, sw[i][0], sw[i][1], sw[i][2]);
            end
            {u_if_w.start_sw, u_if_w.lap_sw, u_if_w.clr_sw} = {sw[0][0], sw[0][1], sw[0][2]};
            {u_if_s.start_sw, u_if_s.lap_sw, u_if_s.clr_sw} = {sw[1][0], sw[1][1], sw[1][2]};
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

`default_nettype wire
